// File: rtl/control_fsm_pkg.sv
// rtl/control_fsm_pkg.sv - shared encodings for the RV32I multi-cycle controller
//
// Contents:
//   opcode_t          RV32I major opcodes presented by the instruction decoder
//   alu_op_t          operation class handed to ALUdecoder
//   state_t           controller state encoding (4 bits)
//   SRC_A_* / SRC_B_* / RES_*   datapath mux select encodings
//   decode_dispatch() DECODE-state successor for a given opcode
package control_fsm_pkg;

   typedef enum logic [6:0] {
      IType_load  = 7'b0000011,
      FENCE       = 7'b0001111,
      IType_logic = 7'b0010011,
      UType_auipc = 7'b0010111,
      SType       = 7'b0100011,
      RType       = 7'b0110011,
      UType_lui   = 7'b0110111,
      BType       = 7'b1100011,
      IType_jalr  = 7'b1100111,
      JType       = 7'b1101111
   } opcode_t;

   typedef enum logic [1:0] {
      ADD                = 2'b00,
      BRANCH             = 2'b01,
      REGISTER_OPERATION = 2'b10,
      UNSET              = 2'b11
   } alu_op_t;

   typedef enum logic [3:0] {
      S_FETCH    = 4'd0,
      S_DECODE   = 4'd1,
      S_MEMADR   = 4'd2,
      S_MEMREAD  = 4'd3,
      S_MEMWB    = 4'd4,
      S_MEMWRITE = 4'd5,
      S_EXECUTER = 4'd6,
      S_EXECUTEI = 4'd7,
      S_ALUWB    = 4'd8,
      S_BRANCH   = 4'd9,
      S_JAL      = 4'd10,
      S_JALR     = 4'd11,
      S_LINK     = 4'd12,
      S_UPPER    = 4'd13,
      S_HALT     = 4'd14
   } state_t;

   localparam logic [1:0] SRC_A_PC      = 2'b00;
   localparam logic [1:0] SRC_A_OLDPC   = 2'b01;
   localparam logic [1:0] SRC_A_REG     = 2'b10;
   localparam logic [1:0] SRC_A_ZERO    = 2'b11;

   localparam logic [1:0] SRC_B_REG     = 2'b00;
   localparam logic [1:0] SRC_B_IMM     = 2'b01;
   localparam logic [1:0] SRC_B_FOUR    = 2'b10;

   localparam logic [1:0] RES_ALUOUT    = 2'b00;
   localparam logic [1:0] RES_MEMDATA   = 2'b01;
   localparam logic [1:0] RES_ALURESULT = 2'b10;

   function automatic state_t decode_dispatch(input opcode_t op);
      case (op)
         IType_load, SType:      return S_MEMADR;
         RType:                  return S_EXECUTER;
         IType_logic:            return S_EXECUTEI;
         BType:                  return S_BRANCH;
         JType:                  return S_JAL;
         IType_jalr:             return S_JALR;
         UType_lui, UType_auipc: return S_UPPER;
         FENCE:                  return S_FETCH;
         default:                return S_HALT;
      endcase
   endfunction

endpackage

// File: rtl/control_fsm.sv
// rtl/control_fsm.sv - multi-cycle main controller for the RV32I core
//
// Ports:
//   clk, reset       core clock; synchronous active-high reset
//   opcode           instruction opcode, sampled in DECODE
//   branch_taken     branch comparator result, used only in BRANCH
//   mem_ready        memory completes the current request this cycle
//   mem_req, mem_write, adr_src            unified memory port control
//   ir_write, pc_write, reg_write          architectural state write strobes
//   alu_src_a, alu_src_b, result_src       datapath mux selects
//   alu_op           operation class for ALUdecoder
//   illegal_instr    sticky; set while parked in HALT
module control_fsm
   import control_fsm_pkg::*;
(
   input  logic       clk,
   input  logic       reset,
   input  opcode_t    opcode,
   input  logic       branch_taken,
   input  logic       mem_ready,
   output logic       mem_req,
   output logic       mem_write,
   output logic       adr_src,
   output logic       ir_write,
   output logic       pc_write,
   output logic       reg_write,
   output logic [1:0] alu_src_a,
   output logic [1:0] alu_src_b,
   output logic [1:0] result_src,
   output alu_op_t    alu_op,
   output logic       illegal_instr
);

   state_t state_q, state_d;
   // Load/store and lui/auipc are only distinguishable at DECODE; remember
   // which one it was for MEMADR and UPPER.
   logic   is_store_q, is_store_d;
   logic   is_lui_q, is_lui_d;

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= S_FETCH;
         is_store_q <= 1'b0;
         is_lui_q   <= 1'b0;
      end else begin
         state_q    <= state_d;
         is_store_q <= is_store_d;
         is_lui_q   <= is_lui_d;
      end
   end

   always_comb begin
      state_d       = state_q;
      is_store_d    = is_store_q;
      is_lui_d      = is_lui_q;
      mem_req       = 1'b0;
      mem_write     = 1'b0;
      adr_src       = 1'b0;
      ir_write      = 1'b0;
      pc_write      = 1'b0;
      reg_write     = 1'b0;
      alu_src_a     = SRC_A_PC;
      alu_src_b     = SRC_B_REG;
      result_src    = RES_ALUOUT;
      alu_op        = UNSET;
      illegal_instr = 1'b0;

      // Reset forces every output quiet, which also drops an in-flight store.
      if (!reset) begin
         case (state_q)
            S_FETCH: begin
               mem_req    = 1'b1;
               alu_src_a  = SRC_A_PC;
               alu_src_b  = SRC_B_FOUR;
               alu_op     = ADD;
               result_src = RES_ALURESULT;
               ir_write   = mem_ready;
               pc_write   = mem_ready;
               if (mem_ready) state_d = S_DECODE;
            end
            S_DECODE: begin
               alu_src_a  = SRC_A_OLDPC;
               alu_src_b  = SRC_B_IMM;
               alu_op     = ADD;
               is_store_d = (opcode == SType);
               is_lui_d   = (opcode == UType_lui);
               state_d    = decode_dispatch(opcode);
            end
            S_MEMADR: begin
               alu_src_a = SRC_A_REG;
               alu_src_b = SRC_B_IMM;
               alu_op    = ADD;
               state_d   = is_store_q ? S_MEMWRITE : S_MEMREAD;
            end
            S_MEMREAD: begin
               mem_req = 1'b1;
               adr_src = 1'b1;
               if (mem_ready) state_d = S_MEMWB;
            end
            S_MEMWB: begin
               result_src = RES_MEMDATA;
               reg_write  = 1'b1;
               state_d    = S_FETCH;
            end
            S_MEMWRITE: begin
               mem_req   = 1'b1;
               mem_write = 1'b1;
               adr_src   = 1'b1;
               if (mem_ready) state_d = S_FETCH;
            end
            S_EXECUTER: begin
               alu_src_a = SRC_A_REG;
               alu_src_b = SRC_B_REG;
               alu_op    = REGISTER_OPERATION;
               state_d   = S_ALUWB;
            end
            S_EXECUTEI: begin
               alu_src_a = SRC_A_REG;
               alu_src_b = SRC_B_IMM;
               alu_op    = REGISTER_OPERATION;
               state_d   = S_ALUWB;
            end
            S_ALUWB: begin
               result_src = RES_ALUOUT;
               reg_write  = 1'b1;
               state_d    = S_FETCH;
            end
            S_BRANCH: begin
               alu_src_a  = SRC_A_REG;
               alu_src_b  = SRC_B_REG;
               alu_op     = BRANCH;
               result_src = RES_ALUOUT;
               pc_write   = branch_taken;
               state_d    = S_FETCH;
            end
            S_JAL: begin
               // Target was computed into ALUOut during DECODE.
               result_src = RES_ALUOUT;
               pc_write   = 1'b1;
               alu_src_a  = SRC_A_OLDPC;
               alu_src_b  = SRC_B_FOUR;
               alu_op     = ADD;
               state_d    = S_ALUWB;
            end
            S_JALR: begin
               alu_src_a  = SRC_A_REG;
               alu_src_b  = SRC_B_IMM;
               alu_op     = ADD;
               result_src = RES_ALURESULT;
               pc_write   = 1'b1;
               state_d    = S_LINK;
            end
            S_LINK: begin
               alu_src_a = SRC_A_OLDPC;
               alu_src_b = SRC_B_FOUR;
               alu_op    = ADD;
               state_d   = S_ALUWB;
            end
            S_UPPER: begin
               alu_src_a = is_lui_q ? SRC_A_ZERO : SRC_A_OLDPC;
               alu_src_b = SRC_B_IMM;
               alu_op    = ADD;
               state_d   = S_ALUWB;
            end
            S_HALT: begin
               illegal_instr = 1'b1;
            end
            default: begin
               state_d = S_HALT;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_control_fsm.sv
// tb/tb_control_fsm.sv - scoreboard bench for control_fsm
module tb_control_fsm;
   import control_fsm_pkg::*;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   opcode_t    opcode = RType;
   logic       branch_taken = 1'b0;
   logic       mem_ready = 1'b0;
   logic       mem_req, mem_write, adr_src, ir_write, pc_write, reg_write;
   logic [1:0] alu_src_a, alu_src_b, result_src;
   alu_op_t    alu_op;
   logic       illegal_instr;

   control_fsm dut (
      .clk          (clk),
      .reset        (reset),
      .opcode       (opcode),
      .branch_taken (branch_taken),
      .mem_ready    (mem_ready),
      .mem_req      (mem_req),
      .mem_write    (mem_write),
      .adr_src      (adr_src),
      .ir_write     (ir_write),
      .pc_write     (pc_write),
      .reg_write    (reg_write),
      .alu_src_a    (alu_src_a),
      .alu_src_b    (alu_src_b),
      .result_src   (result_src),
      .alu_op       (alu_op),
      .illegal_instr(illegal_instr)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic       req;
      logic       wr;
      logic       adr;
      logic       irw;
      logic       pcw;
      logic       rw;
      logic [1:0] sa;
      logic [1:0] sb;
      logic [1:0] rs;
      alu_op_t    op;
      logic       ill;
   } vec_t;

   vec_t  exp_q[$];
   string tag_q[$];
   int    n_tests = 0;
   int    n_fail  = 0;

   function automatic vec_t mk(input logic req, wr, adr, irw, pcw, rw,
                               input logic [1:0] sa, sb, rs,
                               input alu_op_t op, input logic ill);
      vec_t v;
      v.req = req; v.wr = wr; v.adr = adr; v.irw = irw; v.pcw = pcw; v.rw = rw;
      v.sa = sa; v.sb = sb; v.rs = rs; v.op = op; v.ill = ill;
      return v;
   endfunction

   // Hand-written expected output vectors per state.
   function automatic vec_t e_idle();         return mk(0,0,0,0,0,0,2'b00,2'b00,2'b00,UNSET,0);              endfunction
   function automatic vec_t e_fetch(logic r); return mk(1,0,0,r,r,0,2'b00,2'b10,2'b10,ADD,0);                endfunction
   function automatic vec_t e_decode();       return mk(0,0,0,0,0,0,2'b01,2'b01,2'b00,ADD,0);                endfunction
   function automatic vec_t e_memadr();       return mk(0,0,0,0,0,0,2'b10,2'b01,2'b00,ADD,0);                endfunction
   function automatic vec_t e_memread();      return mk(1,0,1,0,0,0,2'b00,2'b00,2'b00,UNSET,0);              endfunction
   function automatic vec_t e_memwb();        return mk(0,0,0,0,0,1,2'b00,2'b00,2'b01,UNSET,0);              endfunction
   function automatic vec_t e_memwrite();     return mk(1,1,1,0,0,0,2'b00,2'b00,2'b00,UNSET,0);              endfunction
   function automatic vec_t e_exr();          return mk(0,0,0,0,0,0,2'b10,2'b00,2'b00,REGISTER_OPERATION,0); endfunction
   function automatic vec_t e_exi();          return mk(0,0,0,0,0,0,2'b10,2'b01,2'b00,REGISTER_OPERATION,0); endfunction
   function automatic vec_t e_aluwb();        return mk(0,0,0,0,0,1,2'b00,2'b00,2'b00,UNSET,0);              endfunction
   function automatic vec_t e_branch(logic t);return mk(0,0,0,0,t,0,2'b10,2'b00,2'b00,BRANCH,0);             endfunction
   function automatic vec_t e_jal();          return mk(0,0,0,0,1,0,2'b01,2'b10,2'b00,ADD,0);                endfunction
   function automatic vec_t e_jalr();         return mk(0,0,0,0,1,0,2'b10,2'b01,2'b10,ADD,0);                endfunction
   function automatic vec_t e_link();         return mk(0,0,0,0,0,0,2'b01,2'b10,2'b00,ADD,0);                endfunction
   function automatic vec_t e_upper(logic l); return mk(0,0,0,0,0,0,l ? 2'b11 : 2'b01,2'b01,2'b00,ADD,0);    endfunction
   function automatic vec_t e_halt();         return mk(0,0,0,0,0,0,2'b00,2'b00,2'b00,UNSET,1);              endfunction

   // Monitor: each cycle that has a scheduled expectation, sample the DUT
   // mid-cycle and compare against the head of the scoreboard.
   always @(negedge clk) begin
      vec_t  e;
      vec_t  a;
      string t;
      if (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         t = tag_q.pop_front();
         a = mk(mem_req, mem_write, adr_src, ir_write, pc_write, reg_write,
                alu_src_a, alu_src_b, result_src, alu_op, illegal_instr);
         n_tests++;
         if (a !== e) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", t, a, e);
         end
      end
   end

   task automatic cyc(input logic rst, input logic rdy, input logic bt,
                      input vec_t e, input string t);
      reset        = rst;
      mem_ready    = rdy;
      branch_taken = bt;
      exp_q.push_back(e);
      tag_q.push_back(t);
      @(posedge clk);
      #1;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      @(posedge clk);
      #1;
      cyc(1, 1, 0, e_idle(), "reset_0");
      cyc(1, 1, 0, e_idle(), "reset_1");

      // add: 4 cycles
      opcode = RType;
      cyc(0, 1, 0, e_fetch(1),  "add_fetch");
      cyc(0, 0, 0, e_decode(),  "add_decode");
      cyc(0, 0, 0, e_exr(),     "add_execr");
      cyc(0, 1, 0, e_aluwb(),   "add_aluwb");

      // lw with three wait cycles in MEMREAD: 8 cycles
      opcode = IType_load;
      cyc(0, 1, 0, e_fetch(1),   "lw_fetch");
      cyc(0, 0, 0, e_decode(),   "lw_decode");
      cyc(0, 1, 0, e_memadr(),   "lw_memadr");
      cyc(0, 0, 0, e_memread(),  "lw_memread_w0");
      cyc(0, 0, 0, e_memread(),  "lw_memread_w1");
      cyc(0, 0, 0, e_memread(),  "lw_memread_w2");
      cyc(0, 1, 0, e_memread(),  "lw_memread_rdy");
      cyc(0, 0, 0, e_memwb(),    "lw_memwb");

      // addi with one wait cycle in FETCH
      opcode = IType_logic;
      cyc(0, 0, 0, e_fetch(0),  "addi_fetch_wait");
      cyc(0, 1, 0, e_fetch(1),  "addi_fetch");
      cyc(0, 1, 0, e_decode(),  "addi_decode");
      cyc(0, 1, 0, e_exi(),     "addi_execi");
      cyc(0, 1, 0, e_aluwb(),   "addi_aluwb");

      // beq not taken, then taken
      opcode = BType;
      cyc(0, 1, 0, e_fetch(1),   "beq0_fetch");
      cyc(0, 1, 1, e_decode(),   "beq0_decode");
      cyc(0, 1, 0, e_branch(0),  "beq0_branch");
      cyc(0, 1, 0, e_fetch(1),   "beq1_fetch");
      cyc(0, 1, 0, e_decode(),   "beq1_decode");
      cyc(0, 1, 1, e_branch(1),  "beq1_branch");

      // jalr: 5 cycles
      opcode = IType_jalr;
      cyc(0, 1, 0, e_fetch(1),  "jalr_fetch");
      cyc(0, 1, 0, e_decode(),  "jalr_decode");
      cyc(0, 1, 0, e_jalr(),    "jalr_jalr");
      cyc(0, 1, 0, e_link(),    "jalr_link");
      cyc(0, 1, 0, e_aluwb(),   "jalr_aluwb");

      // jal: 4 cycles
      opcode = JType;
      cyc(0, 1, 0, e_fetch(1),  "jal_fetch");
      cyc(0, 1, 0, e_decode(),  "jal_decode");
      cyc(0, 1, 0, e_jal(),     "jal_jal");
      cyc(0, 1, 0, e_aluwb(),   "jal_aluwb");

      // lui and auipc
      opcode = UType_lui;
      cyc(0, 1, 0, e_fetch(1),  "lui_fetch");
      cyc(0, 1, 0, e_decode(),  "lui_decode");
      cyc(0, 1, 0, e_upper(1),  "lui_upper");
      cyc(0, 1, 0, e_aluwb(),   "lui_aluwb");
      opcode = UType_auipc;
      cyc(0, 1, 0, e_fetch(1),  "auipc_fetch");
      cyc(0, 1, 0, e_decode(),  "auipc_decode");
      cyc(0, 1, 0, e_upper(0),  "auipc_upper");
      cyc(0, 1, 0, e_aluwb(),   "auipc_aluwb");

      // sw: 4 cycles
      opcode = SType;
      cyc(0, 1, 0, e_fetch(1),    "sw_fetch");
      cyc(0, 1, 0, e_decode(),    "sw_decode");
      cyc(0, 1, 0, e_memadr(),    "sw_memadr");
      cyc(0, 1, 0, e_memwrite(),  "sw_memwrite");

      // fence: 2 cycles
      opcode = FENCE;
      cyc(0, 1, 0, e_fetch(1),  "fence_fetch");
      cyc(0, 1, 0, e_decode(),  "fence_decode");

      // sw abandoned by reset while waiting in MEMWRITE
      opcode = SType;
      cyc(0, 1, 0, e_fetch(1),    "swr_fetch");
      cyc(0, 1, 0, e_decode(),    "swr_decode");
      cyc(0, 1, 0, e_memadr(),    "swr_memadr");
      cyc(0, 0, 0, e_memwrite(),  "swr_memwrite_w0");
      cyc(0, 0, 0, e_memwrite(),  "swr_memwrite_w1");
      cyc(1, 0, 0, e_idle(),      "swr_reset");
      cyc(0, 0, 0, e_fetch(0),    "swr_after_reset");

      // unsupported opcode parks in HALT until reset
      opcode = opcode_t'(7'b0000000);
      cyc(0, 1, 0, e_fetch(1),  "ill_fetch");
      cyc(0, 1, 0, e_decode(),  "ill_decode");
      cyc(0, 1, 0, e_halt(),    "ill_halt_0");
      cyc(0, 1, 1, e_halt(),    "ill_halt_1");
      cyc(0, 1, 0, e_halt(),    "ill_halt_2");
      cyc(1, 1, 0, e_idle(),    "ill_reset");
      opcode = RType;
      cyc(0, 1, 0, e_fetch(1),  "ill_resume_fetch");
      cyc(0, 1, 0, e_decode(),  "ill_resume_decode");

      n_tests++;
      if (exp_q.size() != 0) begin
         n_fail++;
         $display("FAIL scoreboard_drain: got %0d pending expected 0", exp_q.size());
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
